// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the initiator port and the memory responder.
package wb_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } wb_state_e;

endpackage

// File: rtl/wb_master_port_if.sv
// Request/response channels plus the Wishbone classic signals of the initiator.
interface wb_master_port_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_we_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  // View of the initiator port itself.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    output req_ready, resp_valid, resp_rdata, resp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

  // View of whoever drives requests and plays the Wishbone responder.
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Clear/enable cycle counter flagging the last cycle before a bus timeout.
module wb_timeout_ctr #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count;

  // Count cycles spent waiting; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one single-beat cycle per request, with timeout.
module wb_master_port
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_WIDTH       = 16
) (
  input logic               clk,
  input logic               rst_n,
  wb_master_port_if.master  bus
);

  wb_state_e state, state_nxt;

  logic                  accept;
  logic                  term_err;
  logic                  term_ack;
  logic                  term;
  logic                  to_tc;
  logic [DATA_WIDTH-1:0] rdata_nxt;

  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  we_q;
  logic                  cyc_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  wb_timeout_ctr #(
    .WIDTH (TO_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == BUS),
    .tc    (to_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)          state_nxt = BUS;
      BUS:     if (term)            state_nxt = RESP;
      RESP:    if (bus.resp_ready)  state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake and termination decode; err beats ack, ack beats timeout.
  always_comb begin
    bus.req_ready = rst_n && (state == IDLE);
    accept        = bus.req_ready && bus.req_valid;
    term_err      = (state == BUS) && (bus.wb_err_i || (!bus.wb_ack_i && to_tc));
    term_ack      = (state == BUS) && !bus.wb_err_i && bus.wb_ack_i;
    term          = term_err || term_ack;
    rdata_nxt     = '0;
    if (term_ack && !we_q) begin
      rdata_nxt = bus.wb_dat_i;
    end
  end

  // Registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (accept) begin
        adr_q <= bus.req_addr;
        dat_q <= bus.req_wdata;
        we_q  <= bus.req_we;
        cyc_q <= 1'b1;
      end
      if (term) begin
        cyc_q        <= 1'b0;
        resp_valid_q <= 1'b1;
        resp_err_q   <= term_err;
        rdata_q      <= rdata_nxt;
      end
      if ((state == RESP) && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = cyc_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port against a registered-ack memory responder.
module tb_wb_master_port;

  localparam int unsigned TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_master_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  wb_master_port #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (16),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory responder: ack one cycle after cyc/stb, then drop for a cycle.
  logic [31:0]  mem [0:255];
  logic [255:0] mem_vld = '0;
  logic         r_ack;
  logic [31:0]  r_dat;
  logic         mute, f_ack, f_err, f_dat_en;

  assign bus.wb_ack_i = r_ack | f_ack;
  assign bus.wb_err_i = f_err;
  assign bus.wb_dat_i = f_dat_en ? 32'hA5A5_A5A5 : r_dat;

  function automatic logic [31:0] mem_rd(input logic [7:0] a);
    return mem_vld[a] ? mem[a] : {24'hC0FFEE, ~a};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= 1'b0;
      if (bus.wb_cyc_o && bus.wb_stb_o && !r_ack && !mute) begin
        r_ack <= 1'b1;
        r_dat <= mem_rd(bus.wb_adr_o[7:0]);
        if (bus.wb_we_o) begin
          mem[bus.wb_adr_o[7:0]]     <= bus.wb_dat_o;
          mem_vld[bus.wb_adr_o[7:0]] <= 1'b1;
        end
      end
    end
  end

  int unsigned cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns in the first cycle where resp_valid is high.
  task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                      output logic e, output logic [31:0] rd,
                      output int unsigned lat, output int unsigned acc,
                      output int unsigned cyc_hi);
    int unsigned n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (bus.req_ready !== 1'b1) chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    step();
    acc = cyc_no;
    bus.req_valid = 1'b0;
    lat    = 1;
    cyc_hi = 0;
    chk("cyc_stb_first", {30'b0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd3);
    chk("we_first", 32'(bus.wb_we_o), 32'(we));
    if (we) chk("dat_first", bus.wb_dat_o, d);
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      if (bus.wb_cyc_o === 1'b1) begin
        cyc_hi++;
        chk("adr_hold", 32'(bus.wb_adr_o), 32'(a));
        chk("req_ready_bus", 32'(bus.req_ready), 32'd0);
      end
      step();
      lat++;
    end
    if (bus.resp_valid !== 1'b1) chk("resp_valid_wait", 32'(bus.resp_valid), 32'd1);
    chk("cyc_low_at_resp", {30'b0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    e  = bus.resp_err;
    rd = bus.resp_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [18];

  initial begin
    logic        e;
    logic [31:0] rd, held;
    int unsigned lat, acc, prev_acc, cyc_hi;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    mute = 1'b0; f_ack = 1'b0; f_err = 1'b0; f_dat_en = 1'b0;
    prev_acc = 0;

    vt[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1] = '{1'b0, 16'h0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    for (int i = 0; i < 8; i++) begin
      vt[2 + i]  = '{1'b1, 16'(i), 32'(i * 3), 1'b0, 32'h0};
      vt[10 + i] = '{1'b0, 16'(i), 32'h0,      1'b0, 32'(i * 3)};
    end

    // Reset state
    step();
    step();
    chk("rst_ctl", {26'b0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                    bus.resp_valid, bus.resp_err, bus.req_ready}, 32'd0);
    chk("rst_adr", 32'(bus.wb_adr_o), 32'd0);
    chk("rst_dat", bus.wb_dat_o, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);

    // Table: write/read-back and back-to-back traffic, resp_ready high
    for (int i = 0; i < 18; i++) begin
      xfer(vt[i].we, vt[i].addr, vt[i].wdata, e, rd, lat, acc, cyc_hi);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      if (i > 0) chk($sformatf("vec%0d_spacing", i), 32'(acc - prev_acc), 32'd4);
      prev_acc = acc;
      step();
      chk($sformatf("vec%0d_consumed", i), 32'(bus.resp_valid), 32'd0);
    end

    // Backpressure on a read of 0x0001
    xfer(1'b1, 16'h0001, 32'h1234_5678, e, rd, lat, acc, cyc_hi);
    step();
    bus.resp_ready = 1'b0;
    xfer(1'b0, 16'h0001, 32'h0, e, rd, lat, acc, cyc_hi);
    chk("bp_rdata", rd, 32'h1234_5678);
    chk("bp_err", 32'(e), 32'd0);
    held = rd;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp%0d_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp%0d_rdata", k), bus.resp_rdata, held);
      chk($sformatf("bp%0d_ready_cyc", k), {30'b0, bus.req_ready, bus.wb_cyc_o}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    chk("bp_release", {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);

    // Timeout with a silent responder
    mute = 1'b1;
    xfer(1'b0, 16'h0003, 32'h0, e, rd, lat, acc, cyc_hi);
    chk("to_cyc_cycles", 32'(cyc_hi), 32'(TO));
    chk("to_latency", 32'(lat), 32'(TO + 1));
    chk("to_err", 32'(e), 32'd1);
    chk("to_rdata", rd, 32'd0);
    step();

    // err and ack together on the first BUS cycle
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0005;
    step();
    bus.req_valid = 1'b0;
    chk("ea_cyc", 32'(bus.wb_cyc_o), 32'd1);
    f_ack = 1'b1; f_err = 1'b1; f_dat_en = 1'b1;
    step();
    f_ack = 1'b0; f_err = 1'b0; f_dat_en = 1'b0;
    chk("ea_valid", 32'(bus.resp_valid), 32'd1);
    chk("ea_err", 32'(bus.resp_err), 32'd1);
    chk("ea_rdata", bus.resp_rdata, 32'd0);
    step();

    // Async reset mid-BUS, then a stray ack
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0006;
    step();
    bus.req_valid = 1'b0;
    chk("ar_cyc_before", 32'(bus.wb_cyc_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_during", {28'b0, bus.wb_cyc_o, bus.wb_stb_o, bus.resp_valid, bus.req_ready}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_ready_after", 32'(bus.req_ready), 32'd1);
    step();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk("ar_stray_ack", {30'b0, bus.resp_valid, bus.wb_cyc_o}, 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("ar_quiet", {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
    mute = 1'b0;

    // Normal traffic resumes after reset
    xfer(1'b0, 16'h0010, 32'h0, e, rd, lat, acc, cyc_hi);
    chk("post_rst_rdata", rd, 32'hDEAD_BEEF);
    chk("post_rst_err", 32'(e), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Wishbone classic initiator; the master end of the bus that our word-addressed Wishbone memory responds to.
- Converts a simple valid/ready request channel (core load/store or DMA) into one single-beat Wishbone cycle at a time.
- Returns read data or an error on a valid/ready response channel.
- Terminates a hung cycle with a programmable timeout.

Parameters:
- DATA_WIDTH, 32, Wishbone and request data width.
- ADDR_WIDTH, 16, word address width; passed through unchanged to wb_adr_o.
- TIMEOUT_CYCLES, 255, bus cycles to wait for ack/err before forcing error termination; legal range 1 to 65535.
- TO_WIDTH, 16, timeout counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  DATA_WIDTH  read data; 0 on writes and on errors.
- resp_err  out  1  cycle ended by wb_err_i or by timeout.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data; valid only while ack is high.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error; tie to 0 for responders without error support.

Behaviour:
- Reset: one clock, clk; async active-low rst_n.
  - While rst_n is low, all registered outputs are 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, resp_valid, resp_rdata, resp_err.
  - req_ready is 0 during reset. State goes to IDLE and the timeout counter clears.
  - Reset asserted mid-cycle drops cyc/stb immediately, with no response. A late ack after reset release is ignored because cyc is low.
- All Wishbone outputs are registered; no combinational path from wb_*_i to wb_*_o.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch addr/we/wdata into wb_adr_o/wb_we_o/wb_dat_o, set cyc = stb = 1, clear counter, go to BUS.
- BUS:
  - req_ready = 0.
  - cyc/stb/adr/we/dat are held stable every cycle.
  - Counter increments each cycle.
  - Termination priority per cycle: wb_err_i, then wb_ack_i, then timeout (counter == TIMEOUT_CYCLES-1 with neither asserted).
  - On err or timeout: resp_err = 1, resp_rdata = 0.
  - On ack: resp_err = 0, resp_rdata = wb_dat_i for reads, 0 for writes.
  - On any termination: cyc = stb = 0 at that same edge, resp_valid = 1, go to RESP.
- RESP:
  - req_ready = 0.
  - resp_valid, resp_rdata and resp_err are held until resp_ready.
  - On handshake, resp_valid = 0 and go to IDLE.
  - wb_ack_i/wb_err_i are ignored outside BUS. This guarantees at least one idle cycle (cyc low) between bus cycles, which absorbs a responder's registered ack that trails by one cycle.
- Latency against a registered-ack responder:
  - Request handshake at edge 0, cyc high in cycle 1, ack sampled at edge 2, resp_valid in cycle 3.
  - With resp_ready held high, the next request is accepted in cycle 4.
  - Peak throughput is 1 transfer per 4 cycles.
- Single outstanding transfer; no pipelining or burst support.
- wb_adr_o/wb_we_o/wb_dat_o keep their last values when cyc is low. Verification checks them only while cyc is high.
- Timeout of exactly TIMEOUT_CYCLES: err with no ack → resp_valid asserts TIMEOUT_CYCLES+1 cycles after the request handshake.

Decomposition:
- Shared package wb_pkg:
  - FSM state enum: IDLE, BUS, RESP.
  - Default DATA_WIDTH and ADDR_WIDTH constants, shared with the memory responder.
- One natural sub-module: wb_timeout_ctr, a clear/enable counter with a terminal-count flag.
- Everything else stays in wb_master_port.

Test Plan:
- Write then read-back against the memory model: write addr 0x0010 data 0xDEADBEEF, then read 0x0010.
  - Expected: first response resp_err = 0, rdata = 0.
  - Expected: second response rdata = 0xDEADBEEF, err = 0, resp_valid in cycle 3 after each accept.
- Backpressure: hold resp_ready = 0 for 5 cycles after a read of 0x0001 returning 0x12345678.
  - Expected: resp_valid/rdata stable for all 5 cycles, req_ready = 0 throughout, cyc low after termination.
- Timeout: TIMEOUT_CYCLES = 4, responder never acks, read addr 0x0003.
  - Expected: cyc/stb high for exactly 4 cycles, then resp_err = 1 and rdata = 0.
- wb_err_i and wb_ack_i asserted together on the first BUS cycle.
  - Expected: resp_err = 1, rdata = 0, err wins.
- Async reset pulse with rst_n low mid-BUS, not aligned to clk.
  - Expected: cyc/stb/resp_valid go to 0 immediately; after release req_ready = 1, and a stray ack in the next cycle creates no response.
- Back-to-back: 8 sequential writes to addr 0..7 with data = addr*3, resp_ready tied high, then 8 reads of the same addresses.
  - Expected: each request accepted every 4 cycles, cyc low for at least 1 cycle between transfers, read data 0,3,...,21.
